hilo_muldiv: RTL and testbench

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/hilo_muldiv.sv | 152 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op codes, FSM states, iteration count.
// Pure declarations; no latency or flow control of its own.
package hilo_pkg;

  localparam int          ITER_COUNT = 32;
  localparam int          CNT_W      = $clog2(ITER_COUNT);
  localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
// Zero latency; no flow control, the owning FSM decides when the result is taken.
module muldiv_step (
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] rem_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o,
  output logic [31:0] rem_o
);

  logic [32:0] mul_sum;
  logic [32:0] part_rem;
  logic [33:0] diff;

  always_comb begin
    mul_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    // 33-bit partial remainder: previous remainder shifted left, next dividend bit in
    part_rem = {rem_i, acc_i[31]};
    diff     = {1'b0, part_rem} - {2'b00, opnd_i};
    acc_o    = acc_i;
    rem_o    = rem_i;
    if (is_div_i) begin
      if (diff[33]) begin
        rem_o = part_rem[31:0];
        acc_o = {acc_i[63:32], acc_i[30:0], 1'b0};
      end else begin
        rem_o = diff[31:0];
        acc_o = {acc_i[63:32], acc_i[30:0], 1'b1};
      end
    end else begin
      acc_o = {mul_sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; 34 cycles start-to-done, 2 for divide-by-zero.
// busy is high while an operation runs; start and MTHI/MTLO strobes are ignored until it drops.
module hilo_muldiv
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      acc_q;
  logic [31:0]      rem_q;
  logic [31:0]      opnd_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             div_q;
  logic             dz_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;

  op_e         op_in;
  logic        op_signed;
  logic        op_div;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] step_acc;
  logic [31:0] step_rem;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  assign op_in     = op_e'(op);
  assign op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign op_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
  assign b_zero    = (src_b == 32'd0);
  assign a_mag     = (op_signed && src_a[31]) ? neg32(src_a) : src_a;
  assign b_mag     = (op_signed && src_b[31]) ? neg32(src_b) : src_b;

  muldiv_step u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .rem_o    (step_rem)
  );

  // Sign correction applied to the magnitude result while in FIX
  always_comb begin
    prod_fix = qneg_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = qneg_q ? neg32(acc_q[31:0]) : acc_q[31:0];
    rem_fix  = rneg_q ? neg32(rem_q) : rem_q;
    hi_res   = prod_fix[63:32];
    lo_res   = prod_fix[31:0];
    if (div_q) begin
      if (dz_q) begin
        hi_res = acc_q[31:0];
        lo_res = DIV0_LO;
      end else begin
        hi_res = rem_fix;
        lo_res = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_write) hi_q <= wdata;
          if (lo_write) lo_q <= wdata;
          if (start) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            opnd_q <= b_mag;
            div_q  <= op_div;
            busy_q <= 1'b1;
            if (op_div && b_zero) begin
              // raw dividend parked in acc so FIX can return it as HI
              acc_q   <= {32'd0, src_a};
              dz_q    <= 1'b1;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= FIX;
            end else begin
              acc_q   <= {32'd0, a_mag};
              dz_q    <= 1'b0;
              qneg_q  <= op_signed & (src_a[31] ^ src_b[31]);
              rneg_q  <= op_signed & src_a[31];
              state_q <= op_div ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          acc_q <= step_acc;
          rem_q <= step_rem;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_res;
          lo_q    <= lo_res;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected HI/LO plus done cycle, a monitor pops on done.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  hilo_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  logic prev_done = 1'b0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check32("done_single_pulse", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e = sb.pop_front();
        check32("result_hi", hi, mon_e.hi);
        check32("result_lo", lo, mon_e.lo);
        check32("done_cycle", cyc, mon_e.due);
      end
    end
    prev_done = done;
  end

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    if (push) sb.push_back('{ehi, elo, cyc + lat});
    @(posedge clk);
    #1;
    start    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    check32("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
    @(negedge clk);
    hi_write = wh;
    lo_write = wl;
    wdata    = d;
    @(posedge clk);
    #1;
    hi_write = 1'b0;
    lo_write = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mt_write(1'b1, 1'b0, 32'h0000_1234);
    check32("mthi_hi", hi, 32'h0000_1234);
    check32("mthi_lo", lo, 32'd0);
    mt_write(1'b0, 1'b1, 32'h0000_5678);
    check32("mtlo_lo", lo, 32'h0000_5678);
    check32("mtlo_hi", hi, 32'h0000_1234);
    mt_write(1'b1, 1'b1, 32'h0000_CAFE);
    check32("mtboth_hi", hi, 32'h0000_CAFE);
    check32("mtboth_lo", lo, 32'h0000_CAFE);

    // MTHI together with start: write lands now, result overwrites later
    @(negedge clk);
    hi_write = 1'b1;
    wdata    = 32'hAAAA_5555;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 34);
    check32("mt_with_start_hi", hi, 32'hAAAA_5555);
    check32("mt_with_start_lo", lo, 32'h0000_CAFE);
    wait_idle("mult");

    @(negedge clk);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    wait_idle("multu");

    @(negedge clk);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    wait_idle("div_neg7_2");

    @(negedge clk);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 34);
    wait_idle("div_wrap");

    @(negedge clk);
    issue(OP_DIVU, 32'd7, 32'd0, 1'b1, 32'd7, 32'hFFFF_FFFF, 2);
    wait_idle("divu_by_zero");

    // Strobes while busy must not disturb the running MULTU
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    check32("mthi_before_multu", hi, 32'h0000_1234);
    @(negedge clk);
    issue(OP_MULTU, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, 34);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    op       = OP_DIV;
    src_a    = 32'd99;
    src_b    = 32'd3;
    lo_write = 1'b1;
    wdata    = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lo_write = 1'b0;
    check32("busy_ignore_lo", lo, 32'hFFFF_FFFF);
    check32("busy_ignore_hi", hi, 32'h0000_1234);
    check32("busy_ignore_busy", {31'd0, busy}, 32'd1);
    wait_idle("multu_busy_ignore");

    @(negedge clk);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 34);
    wait_idle("div_7_neg2");

    // Reset partway through a DIV: no result, no done
    @(negedge clk);
    issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd0, 32'd0, 0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("midop_reset_hi", hi, 32'd0);
    check32("midop_reset_lo", lo, 32'd0);
    check32("midop_reset_busy", {31'd0, busy}, 32'd0);
    check32("midop_reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 34);
    wait_idle("divu_after_reset");

    repeat (3) @(negedge clk);
    check32("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
